// File: rtl/timer_pkg.sv
// Shared types, limits and the Mode B preset helper for the mode_timer slice.
package timer_pkg;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MAX_SEC = 6'd59;
  localparam logic [CNT_W-1:0] MAX_MIN = 6'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Countdown preset: TimeControl selects 1..8 whole minutes
  function automatic logic [CNT_W-1:0] preset_min(input logic [2:0] tc);
    return {3'b000, tc} + 6'd1;
  endfunction
endpackage

// File: rtl/mode_timer_if.sv
// Control/display bundle of mode_timer; the lap input exists only with TIMER_LAP_EN.
interface mode_timer_if;
  import timer_pkg::*;
  logic             resetter;
  logic             ModeSel;
  logic [2:0]       TimeControl;
  logic             tick;
  logic             start_stop;
  logic [CNT_W-1:0] minutes;
  logic [CNT_W-1:0] seconds;
  logic             running;
  logic             done;
`ifdef TIMER_LAP_EN
  logic             lap;
  modport master (output resetter, ModeSel, TimeControl, tick, start_stop, lap,
                  input  minutes, seconds, running, done);
  modport slave  (input  resetter, ModeSel, TimeControl, tick, start_stop, lap,
                  output minutes, seconds, running, done);
`else
  modport master (output resetter, ModeSel, TimeControl, tick, start_stop,
                  input  minutes, seconds, running, done);
  modport slave  (input  resetter, ModeSel, TimeControl, tick, start_stop,
                  output minutes, seconds, running, done);
`endif
endinterface

// File: rtl/min_sec_counter.sv
// Up/down minutes:seconds counter with parallel load, carry/borrow and zero detect.
module min_sec_counter
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_min,
  input  logic [CNT_W-1:0] load_sec,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_min,
  output logic [CNT_W-1:0] cnt_sec,
  output logic             zero,
  output logic             last
);
  assign zero = (cnt_min == '0) && (cnt_sec == '0);
  assign last = (cnt_min == '0) && (cnt_sec == 6'd1);

  always_ff @(posedge clk) begin
    if (load) begin
      cnt_min <= load_min;
      cnt_sec <= load_sec;
    end else if (en) begin
      if (up) begin
        if (cnt_sec == MAX_SEC) begin
          cnt_sec <= '0;
          cnt_min <= (cnt_min == MAX_MIN) ? '0 : cnt_min + 6'd1;
        end else begin
          cnt_sec <= cnt_sec + 6'd1;
        end
      end else if (!zero) begin
        // Countdown never wraps below 00:00
        if (cnt_sec == '0) begin
          cnt_sec <= MAX_SEC;
          cnt_min <= cnt_min - 6'd1;
        end else begin
          cnt_sec <= cnt_sec - 6'd1;
        end
      end
    end
  end
endmodule

// File: rtl/mode_timer.sv
// Stopwatch / countdown timer: start_stop edge detect, run FSM and display path.
// Optional lap freeze of the display is built with TIMER_LAP_EN.
module mode_timer
  import timer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mode_timer_if.slave  bus
);
  state_t           state, state_nxt;
  logic             ss_q, pulse, mode_q;
  logic             load, cnt_en, zero, last;
  logic [CNT_W-1:0] load_min, cnt_min, cnt_sec;

  assign load     = rst | bus.resetter;
  assign load_min = bus.ModeSel ? preset_min(bus.TimeControl) : '0;

  // Mode is latched only on a clear so mid-run ModeSel changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ss_q   <= bus.start_stop;  // a held button must not look like a new press
      pulse  <= 1'b0;
      mode_q <= bus.ModeSel;
    end else begin
      state  <= state_nxt;
      ss_q   <= bus.start_stop;
      pulse  <= bus.start_stop & ~ss_q;
      if (bus.resetter) mode_q <= bus.ModeSel;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    if (bus.resetter) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (pulse) state_nxt = RUN;
        RUN: begin
          if (pulse) begin
            state_nxt = PAUSE;
          end else if (mode_q && zero) begin
            state_nxt = DONE;
          end else if (bus.tick) begin
            cnt_en = 1'b1;
            if (mode_q && last) state_nxt = DONE;
          end
        end
        PAUSE: if (pulse) state_nxt = RUN;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  min_sec_counter u_cnt (
    .clk      (clk),
    .load     (load),
    .load_min (load_min),
    .load_sec ('0),
    .en       (cnt_en),
    .up       (~mode_q),
    .cnt_min  (cnt_min),
    .cnt_sec  (cnt_sec),
    .zero     (zero),
    .last     (last)
  );

  assign bus.running = (state == RUN);
  assign bus.done    = (state == DONE);

`ifdef TIMER_LAP_EN
  logic             frozen;
  logic [CNT_W-1:0] lap_min, lap_sec;

  always_ff @(posedge clk) begin
    if (load || !bus.lap) begin
      frozen <= 1'b0;
    end else if (!frozen && state == RUN && !mode_q) begin
      frozen  <= 1'b1;
      lap_min <= cnt_min;
      lap_sec <= cnt_sec;
    end
  end

  assign bus.minutes = frozen ? lap_min : cnt_min;
  assign bus.seconds = frozen ? lap_sec : cnt_sec;
`else
  assign bus.minutes = cnt_min;
  assign bus.seconds = cnt_sec;
`endif
endmodule
